sync2ncl_tx: RTL and testbench

Clocked-to-NCL boundary transmitter. It accepts single-rail words from synchronous logic over a valid/ready handshake. It encodes each word as a dual-rail NCL DATA wavefront, then returns the rails to NULL, paced by the asynchronous `ki` completion signal from the first NCL stage downstream. It sits at the entry of every NCL pipeline built from the static/threshold gate library and is that pipeline's only clocked source.

---
 rtl/ncl_boundary_pkg.sv | 42 ++++
 rtl/ncl_ki_sync.sv | 40 ++++
 rtl/sync2ncl_tx.sv | 160 ++++++++++++++++
 tb/tb_sync2ncl_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ncl_boundary_pkg.sv
// ---------------------------------------------------------------------------
// ncl_boundary_pkg
// Shared definitions for the clocked <-> NCL boundary blocks.
//   tx_state_e       : transmitter sequencing states
//   KI_RFD / KI_RFN  : meaning of the downstream completion signal
//   TIMEOUT_DEFAULT  : default watchdog limit per ki phase, in clk cycles
//   dr_rails_t       : {t, f} dual-rail pair, sized for the widest word
//   dr_encode()      : single-rail word -> dual-rail DATA wavefront
// ---------------------------------------------------------------------------
package ncl_boundary_pkg;

  typedef enum logic [2:0] {
    WAIT_RFD,
    IDLE,
    DATA,
    NUL,
    ERR
  } tx_state_e;

  localparam logic KI_RFD = 1'b1;  // downstream requests DATA
  localparam logic KI_RFN = 1'b0;  // downstream requests NULL

  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  // Widest word the encoder handles; users slice the low WIDTH bits.
  localparam int unsigned DR_MAX_W = 64;

  typedef struct packed {
    logic [DR_MAX_W-1:0] t;
    logic [DR_MAX_W-1:0] f;
  } dr_rails_t;

  // DATA wavefront: rail1 carries the bit, rail0 its complement, so exactly
  // one rail per bit is high.
  function automatic dr_rails_t dr_encode(input logic [DR_MAX_W-1:0] d);
    dr_rails_t r;
    r.t = d;
    r.f = ~d;
    return r;
  endfunction

endpackage

// File: rtl/ncl_ki_sync.sv
// ---------------------------------------------------------------------------
// ncl_ki_sync
// STAGES-deep flop chain bringing an asynchronous NCL completion signal into
// the clk domain. Resets to 0 (rfn), so a freshly reset sender never assumes
// the downstream is ready.
//   clk : sampling clock
//   rst : asynchronous, active-high reset
//   d   : asynchronous input (ki)
//   q   : synchronized output (ki_s), STAGES edges behind d
// STAGES must be at least 2.
// ---------------------------------------------------------------------------
module ncl_ki_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // NOTE: reset sits in the sensitivity list so it acts without a clock, and
  // sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sync2ncl_tx.sv
// ---------------------------------------------------------------------------
// sync2ncl_tx
// Clocked-to-NCL boundary transmitter. Accepts single-rail words over
// valid/ready, drives each as a dual-rail DATA wavefront, then returns the
// rails to NULL, paced by the downstream completion signal ki.
//   clk       : single clock, rising edge
//   rst       : asynchronous, active-high reset
//   in_data   : single-rail word (WIDTH bits, WIDTH < 64)
//   in_valid  : in_data is valid
//   in_ready  : high exactly while IDLE; accept on in_valid && in_ready
//   out_t     : rail1 of each dual-rail bit
//   out_f     : rail0 of each dual-rail bit
//   ki        : async completion, 1 = rfd, 0 = rfn
//   err       : sticky watchdog error
//   tx_count  : completed DATA/NULL cycles, wraps at 16 bits
// Every output is a flop: the rails feed threshold gates directly, so no
// combinational glitch may reach them.
// ---------------------------------------------------------------------------
module sync2ncl_tx
  import ncl_boundary_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_t,
  output logic [WIDTH-1:0] out_f,
  input  logic             ki,
  output logic             err,
  output logic [15:0]      tx_count
);

  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT - 1);

  logic ki_s;

  ncl_ki_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ki_sync (
    .clk(clk),
    .rst(rst),
    .d  (ki),
    .q  (ki_s)
  );

  // Encode at full package width; only the low WIDTH bits of each rail are
  // meaningful, the upper bits are discarded.
  logic [WIDTH-1:0]          enc_t;
  logic [WIDTH-1:0]          enc_f;
  logic [DR_MAX_W-WIDTH-1:0] enc_t_unused;
  logic [DR_MAX_W-WIDTH-1:0] enc_f_unused;

  assign {enc_t_unused, enc_t, enc_f_unused, enc_f} = dr_encode(DR_MAX_W'(in_data));

  tx_state_e        state_q,    state_d;
  logic [WIDTH-1:0] out_t_q,    out_t_d;
  logic [WIDTH-1:0] out_f_q,    out_f_d;
  logic             in_ready_q, in_ready_d;
  logic             err_q,      err_d;
  logic [15:0]      tx_count_q, tx_count_d;
  logic [15:0]      wdog_q,     wdog_d;

  // NOTE: every _d gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    tx_count_d = tx_count_q;

    case (state_q)
      WAIT_RFD: begin
        if (ki_s == KI_RFD) state_d = IDLE;
      end
      IDLE: begin
        if (in_valid && in_ready_q) state_d = DATA;
      end
      DATA: begin
        // The awaited ki_s edge takes priority over an expiring watchdog.
        if (ki_s == KI_RFN) begin
          state_d = NUL;
        end else if (wdog_q == WDOG_LIMIT) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      NUL: begin
        if (ki_s == KI_RFD) begin
          state_d    = IDLE;
          tx_count_d = tx_count_q + 16'd1;
        end else if (wdog_q == WDOG_LIMIT) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = WAIT_RFD;
      end
    endcase

    // Rails are a pure function of the next state: NULL everywhere except
    // DATA, loaded once on entry and held until the state is left.
    if (state_d != DATA) begin
      out_t_d = '0;
      out_f_d = '0;
    end else if (state_q == DATA) begin
      out_t_d = out_t_q;
      out_f_d = out_f_q;
    end else begin
      out_t_d = enc_t;
      out_f_d = enc_f;
    end

    in_ready_d = (state_d == IDLE);

    // Watchdog restarts on every state entry and only runs while waiting
    // on the downstream.
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (state_q == DATA || state_q == NUL) begin
      wdog_d = wdog_q + 16'd1;
    end else begin
      wdog_d = wdog_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_RFD;
      out_t_q    <= '0;
      out_f_q    <= '0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
      tx_count_q <= '0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      out_t_q    <= out_t_d;
      out_f_q    <= out_f_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
      tx_count_q <= tx_count_d;
      wdog_q     <= wdog_d;
    end
  end

  assign out_t    = out_t_q;
  assign out_f    = out_f_q;
  assign in_ready = in_ready_q;
  assign err      = err_q;
  assign tx_count = tx_count_q;

endmodule

// File: tb/tb_sync2ncl_tx.sv
// ---------------------------------------------------------------------------
// tb_sync2ncl_tx
// Directed bench for sync2ncl_tx (WIDTH=8, SYNC_STAGES=2, TIMEOUT=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sync2ncl_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_t;
  logic [7:0]  out_f;
  logic        ki;
  logic        err;
  logic [15:0] tx_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync2ncl_tx #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .TIMEOUT    (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_t   (out_t),
    .out_f   (out_f),
    .ki      (ki),
    .err     (err),
    .tx_count(tx_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Both rails of a bit must never be high together.
  always @(negedge clk) begin
    if (rst === 1'b0) check("rails_exclusive", 32'(out_t & out_f), 32'h0);
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, 32'(in_ready), 32'h1);
  endtask

  // One full DATA/NULL cycle with an instantly responding downstream.
  // hold=1 leaves in_valid asserted afterwards (back-to-back upstream).
  task automatic send_word(input logic [7:0] d, input bit hold, input logic [15:0] exp_count);
    logic [7:0] nd;
    nd = ~d;
    wait_ready("send");
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    check("data_t", 32'(out_t), 32'(d));
    check("data_f", 32'(out_f), 32'(nd));
    check("data_busy", 32'(in_ready), 32'h0);
    ki = 1'b0;
    repeat (2) @(negedge clk);
    check("data_held_t", 32'(out_t), 32'(d));
    @(negedge clk);
    check("null_t", 32'(out_t), 32'h0);
    check("null_f", 32'(out_f), 32'h0);
    ki = 1'b1;
    repeat (2) @(negedge clk);
    check("nul_busy", 32'(in_ready), 32'h0);
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'h1);
    check("tx_count", 32'(tx_count), 32'(exp_count));
  endtask

  initial begin
    rst      = 1'b1;
    ki       = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state.
    #12;
    check("rst_out_t", 32'(out_t), 32'h0);
    check("rst_out_f", 32'(out_f), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_count", 32'(tx_count), 32'h0);

    // Release with ki=1: ready after SYNC_STAGES+1 = 3 edges.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("wait_rfd_1", 32'(in_ready), 32'h0);
    @(negedge clk);
    check("wait_rfd_2", 32'(in_ready), 32'h0);
    @(negedge clk);
    check("wait_rfd_done", 32'(in_ready), 32'h1);
    check("wait_rfd_rails", 32'(out_t | out_f), 32'h0);

    // Single word: rails A5 / 5A, count 1.
    send_word(8'hA5, 1'b0, 16'd1);

    // Back-to-back with in_valid held throughout.
    send_word(8'h00, 1'b1, 16'd2);
    send_word(8'hFF, 1'b1, 16'd3);
    send_word(8'h3C, 1'b0, 16'd4);

    // ki_s falls on the very cycle the watchdog hits its limit: no error.
    wait_ready("tie");
    in_data  = 8'h5E;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("tie_data", 32'(out_t), 32'h5E);
    repeat (13) @(negedge clk);
    ki = 1'b0;
    repeat (2) @(negedge clk);
    check("tie_still_data", 32'(out_t), 32'h5E);
    check("tie_no_err_a", 32'(err), 32'h0);
    @(negedge clk);
    check("tie_null", 32'(out_t | out_f), 32'h0);
    check("tie_no_err_b", 32'(err), 32'h0);
    ki = 1'b1;
    repeat (2) @(negedge clk);
    check("tie_nul_busy", 32'(in_ready), 32'h0);
    @(negedge clk);
    check("tie_ready", 32'(in_ready), 32'h1);
    check("tie_count", 32'(tx_count), 32'd5);

    // Counter wrap: preload 0xFFFF, then two transfers give 0 then 1.
    force dut.tx_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.tx_count_q;
    check("wrap_preload", 32'(tx_count), 32'hFFFF);
    send_word(8'h81, 1'b0, 16'd0);
    send_word(8'h42, 1'b0, 16'd1);

    // Reset mid-DATA: rails clear with no clock edge.
    wait_ready("rstmid");
    in_data  = 8'h77;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstmid_t", 32'(out_t), 32'h77);
    check("rstmid_f", 32'(out_f), 32'h88);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_async_t", 32'(out_t), 32'h0);
    check("rstmid_async_f", 32'(out_f), 32'h0);
    check("rstmid_count", 32'(tx_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_wait_rfd", 32'(in_ready), 32'h0);
    @(negedge clk);
    check("rstmid_restart", 32'(in_ready), 32'h1);
    send_word(8'h99, 1'b0, 16'd1);

    // Watchdog: ki stays rfd after accepting 0x11, err after 16 DATA cycles.
    wait_ready("wdog");
    in_data  = 8'h11;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("wdog_data", 32'(out_t), 32'h11);
    repeat (15) @(negedge clk);
    check("wdog_pre_t", 32'(out_t), 32'h11);
    check("wdog_pre_err", 32'(err), 32'h0);
    @(negedge clk);
    check("wdog_err", 32'(err), 32'h1);
    check("wdog_null", 32'(out_t | out_f), 32'h0);
    check("wdog_busy", 32'(in_ready), 32'h0);
    in_valid = 1'b1;
    ki = 1'b0;
    repeat (4) @(negedge clk);
    ki = 1'b1;
    repeat (4) @(negedge clk);
    check("err_sticky", 32'(err), 32'h1);
    check("err_not_ready", 32'(in_ready), 32'h0);
    check("err_rails", 32'(out_t | out_f), 32'h0);
    in_valid = 1'b0;

    // Only reset leaves ERR.
    rst = 1'b1;
    #1;
    check("err_cleared", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_err_ready", 32'(in_ready), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
